// File: rtl/sub3_pkg.sv
// Shared types and constants for the radix-4 serial three-operand subtractor.
// Digit width, FSM state encoding and the digit-cycle count helper.
package sub3_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_k(input int n);
    return (n + DIGIT_W - 1) / DIGIT_W;
  endfunction

endpackage

// File: rtl/sub2_digit.sv
// Combinational one-digit (2-bit) subtract with borrow in and borrow out.
// Pure logic; the caller registers the borrow between digits.
module sub2_digit
  import sub3_pkg::*;
(
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  logic               b_i,
  output logic [DIGIT_W-1:0] d_o,
  output logic               b_o
);

  logic [DIGIT_W:0] diff;

  // Top bit of the one-bit-wider difference is the borrow out
  always_comb begin
    diff = {1'b0, x_i} - {1'b0, y_i} - {{DIGIT_W{1'b0}}, b_i};
    d_o  = diff[DIGIT_W-1:0];
    b_o  = diff[DIGIT_W];
  end

endmodule

// File: rtl/sub3_serial.sv
// Digit-serial a - b - c, two bits per cycle, LSB digit first.
// Two chained digit subtractors, each with its own registered borrow.
module sub3_serial
  import sub3_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] y,
  output logic         neg,
  output logic         busy,
  output logic         done
);

  localparam int K  = calc_k(N);
  localparam int W  = K * DIGIT_W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_e state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  res_q, res_d;
  logic          br1_q, br1_d;
  logic          br2_q, br2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_q, y_d;
  logic          neg_q, neg_d;

  logic [DIGIT_W-1:0] d1;
  logic [DIGIT_W-1:0] ydig;
  logic               bo1;
  logic               bo2;
  logic               last;

  sub2_digit u_stage1 (
    .x_i (a_q[DIGIT_W-1:0]),
    .y_i (b_q[DIGIT_W-1:0]),
    .b_i (br1_q),
    .d_o (d1),
    .b_o (bo1)
  );

  sub2_digit u_stage2 (
    .x_i (d1),
    .y_i (c_q[DIGIT_W-1:0]),
    .b_i (br2_q),
    .d_o (ydig),
    .b_o (bo2)
  );

  assign last = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    br1_d   = br1_q;
    br2_d   = br2_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = W'(a);
          b_d     = W'(b);
          c_d     = W'(c);
          res_d   = '0;
          br1_d   = 1'b0;
          br2_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT_W;
        b_d   = b_q >> DIGIT_W;
        c_d   = c_q >> DIGIT_W;
        res_d = (res_q >> DIGIT_W)
              | (W'(ydig) << (W - DIGIT_W));
        br1_d = bo1;
        br2_d = bo2;
        cnt_d = cnt_q + CW'(1);
        // Publish only the finished word so y never shows partials
        if (last) begin
          state_d = DONE;
          y_d     = res_d[N-1:0];
          neg_d   = bo1 | bo2;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      br1_q   <= 1'b0;
      br2_q   <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      br1_q   <= br1_d;
      br2_q   <= br2_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      neg_q   <= neg_d;
    end
  end

  assign y    = y_q;
  assign neg  = neg_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sub3_serial.sv
// Bench for sub3_serial at N=16 and N=13 against a cycle-timeline model.
// Directed operations plus literal expected results.
module tb_sub3_serial;

  logic        clk;
  logic        rst_n;
  logic        start16;
  logic        start13;
  logic [15:0] a16, b16, c16;
  logic [12:0] a13, b13, c13;
  logic [15:0] y16;
  logic [12:0] y13;
  logic        neg16, busy16, done16;
  logic        neg13, busy13, done13;

  int checks;
  int errors;

  sub3_serial #(.N(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .c     (c16),
    .y     (y16),
    .neg   (neg16),
    .busy  (busy16),
    .done  (done16)
  );

  sub3_serial #(.N(13)) u_dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start13),
    .a     (a13),
    .b     (b13),
    .c     (c13),
    .y     (y13),
    .neg   (neg13),
    .busy  (busy13),
    .done  (done13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: an op accepted at cycle t is busy for t+1..t+K, done at t+K+1
  int          kk [2] = '{8, 7};
  int          nn [2] = '{16, 13};
  int          cyc [2];
  int          acc [2];
  logic [15:0] pend_y [2];
  logic        pend_n [2];
  logic [15:0] cur_y [2];
  logic        cur_n [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cyc[i]   = 0;
        acc[i]   = -100;
        cur_y[i] = '0;
        cur_n[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic        st;
        logic        idle;
        logic [31:0] ma, mb, mc, full, mask;
        st   = (i == 0) ? start16 : start13;
        ma   = (i == 0) ? 32'(a16) : 32'(a13);
        mb   = (i == 0) ? 32'(b16) : 32'(b13);
        mc   = (i == 0) ? 32'(c16) : 32'(c13);
        idle = !(cyc[i] >= acc[i] + 1 && cyc[i] <= acc[i] + kk[i] + 1);
        if (st && idle) begin
          acc[i]    = cyc[i];
          mask      = (32'd1 << nn[i]) - 32'd1;
          full      = ma - mb - mc;
          pend_y[i] = 16'(full & mask);
          pend_n[i] = (ma < mb + mc);
        end
        cyc[i]++;
        if (cyc[i] == acc[i] + kk[i] + 1) begin
          cur_y[i] = pend_y[i];
          cur_n[i] = pend_n[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic eb, ed;
      eb = (cyc[i] >= acc[i] + 1) && (cyc[i] <= acc[i] + kk[i]);
      ed = (cyc[i] == acc[i] + kk[i] + 1);
      if (i == 0) begin
        chk("m16_busy", 32'(busy16), 32'(eb));
        chk("m16_done", 32'(done16), 32'(ed));
        chk("m16_y", 32'(y16), 32'(cur_y[0]));
        chk("m16_neg", 32'(neg16), 32'(cur_n[0]));
      end else begin
        chk("m13_busy", 32'(busy13), 32'(eb));
        chk("m13_done", 32'(done13), 32'(ed));
        chk("m13_y", 32'(y13), 32'(cur_y[1][12:0]));
        chk("m13_neg", 32'(neg13), 32'(cur_n[1]));
      end
    end
  end

  task automatic op(input int inst, input logic [15:0] oa,
                    input logic [15:0] ob, input logic [15:0] oc,
                    input logic [15:0] ey, input logic en);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    @(negedge clk);
    if (inst == 0) begin
      a16 = oa; b16 = ob; c16 = oc; start16 = 1'b1;
    end else begin
      a13 = oa[12:0]; b13 = ob[12:0]; c13 = oc[12:0]; start13 = 1'b1;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start16 = 1'b0;
      start13 = 1'b0;
      n++;
      if ((inst == 0) ? done16 : done13) break;
      if ((inst == 0) ? busy16 : busy13) nb++;
    end
    chk("lit_done_cycle", 32'(n), 32'(kk[inst] + 1));
    chk("lit_busy_cycles", 32'(nb), 32'(kk[inst]));
    if (inst == 0) begin
      chk("lit_y16", 32'(y16), 32'(ey));
      chk("lit_neg16", 32'(neg16), 32'(en));
    end else begin
      chk("lit_y13", 32'(y13), 32'(ey[12:0]));
      chk("lit_neg13", 32'(neg13), 32'(en));
    end
  endtask

  initial begin
    int ndone;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start16 = 1'b0;
    start13 = 1'b0;
    a16 = '0; b16 = '0; c16 = '0;
    a13 = '0; b13 = '0; c13 = '0;
    repeat (2) @(negedge clk);
    chk("rst_y16", 32'(y16), 32'h0);
    chk("rst_busy16", 32'(busy16), 32'h0);
    chk("rst_done13", 32'(done13), 32'h0);
    rst_n = 1'b1;

    op(0, 16'd100, 16'd30, 16'd20, 16'd50, 1'b0);
    op(0, 16'd5, 16'd3, 16'd4, 16'hFFFE, 1'b1);
    op(0, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 1'b0);
    op(0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h0002, 1'b1);

    // start held through RUN while operands churn
    ndone = 0;
    @(negedge clk);
    a16 = 16'd1000; b16 = 16'd300; c16 = 16'd200; start16 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done16) ndone++;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 16'($urandom);
    end
    @(negedge clk);
    if (done16) ndone++;
    chk("hold_y16", 32'(y16), 32'd500);
    start16 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    chk("hold_ndone", 32'(ndone), 32'd1);

    // asynchronous reset in RUN cycle 4
    @(negedge clk);
    a16 = 16'd9; b16 = 16'd1; c16 = 16'd1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y16", 32'(y16), 32'h0);
    chk("arst_neg16", 32'(neg16), 32'h0);
    chk("arst_busy16", 32'(busy16), 32'h0);
    chk("arst_done16", 32'(done16), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(0, 16'd7, 16'd2, 16'd1, 16'd4, 1'b0);

    op(1, 16'h1000, 16'h1, 16'h1, 16'h0FFE, 1'b0);
    op(1, 16'h0, 16'h0, 16'h1, 16'h1FFF, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
